multicycle_controller: RTL and testbench

- Sequencing FSM for the multicycle RV32I core. It replaces the single-cycle decode path when the core shares one unified instruction/data memory and one ALU across cycles.
- Drives every datapath mux select and write strobe, one state per datapath step.
- Resolves conditional branches from ALU flags.
- Tolerates variable-latency memory through a ready handshake, with a timeout.

---
 rtl/multicycle_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: one state per datapath step,
// branch resolution from ALU flags, and a ready handshake with timeout toward memory.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       instr_retired,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRPC   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The timeout fires on the TIMEOUT-th consecutive cycle without mem_ready.
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] wait_cnt;
    logic          fault_q;
    logic          waiting;
    logic          timeout_hit;
    logic          take;

    assign waiting     = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout_hit = TO_EN && !mem_ready && (wait_cnt == TO_LAST);
    assign fault       = fault_q;

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = Zero;
            3'b001:  take = !Zero;
            3'b100:  take = ALUR31;
            3'b101:  take = !ALUR31;
            3'b110:  take = lt;
            3'b111:  take = !lt;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)        nxt = S_DECODE;
                else if (timeout_hit) nxt = S_FAULT;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_REG:            nxt = S_EXECR;
                    OP_IMM:            nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR;
                    OP_LUI:            nxt = S_LUI;
                    OP_AUIPC:          nxt = S_AUIPC;
                    default:           nxt = S_FAULT;
                endcase
            end
            S_MEMADR:   nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)        nxt = S_MEMWB;
                else if (timeout_hit) nxt = S_FAULT;
            end
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)        nxt = S_FETCH;
                else if (timeout_hit) nxt = S_FAULT;
            end
            S_EXECR, S_EXECI, S_JAL, S_JALRPC, S_AUIPC: nxt = S_ALUWB;
            S_ALUWB, S_BRANCH, S_LUI:                  nxt = S_FETCH;
            S_JALR:     nxt = S_JALRPC;
            S_FAULT:    nxt = S_FAULT;
            default:    nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + TW'(1);
            if (nxt == S_FAULT)
                fault_q <= 1'b1;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                 ImmSrc = 3'b001;
            OP_BRANCH:                ImmSrc = 3'b010;
            OP_JAL:                   ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:         ImmSrc = 3'b100;
            default:                  ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        instr_retired = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                MemWrite      = 1'b1;
                instr_retired = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB, S_LUI: begin
                ResultSrc     = (state == S_LUI) ? 2'b11 : 2'b00;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 2'b10;
                ALUOp         = 2'b01;
                PCWrite       = take;
                instr_retired = 1'b1;
            end
            S_JAL, S_JALRPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
        // Reset abandons any access in flight, so no strobe may leak out.
        if (reset) begin
            PCWrite       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            instr_retired = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction and branch vector tables
// plus hand-written sequences for memory waits, timeout, illegal opcode and reset.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       Zero = 1'b0, ALUR31 = 1'b0, lt = 1'b0, mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_retired, fault;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    multicycle_controller #(.TIMEOUT(4), .TW(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
        .ALUR31(ALUR31), .lt(lt), .mem_ready(mem_ready), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .instr_retired(instr_retired), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       zero;
        logic [2:0] imm;
        int         cycles;
        int         rw;
        int         pcw;
        int         mw;
    } ivec_t;

    typedef struct {
        logic [2:0] f3;
        logic       zero;
        logic       r31;
        logic       ltv;
        logic       take;
    } bvec_t;

    ivec_t itab[9];
    bvec_t btab[14];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic int strobes();
        return int'({PCWrite, MemWrite, IRWrite, RegWrite, instr_retired});
    endfunction

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b1; op = '0; funct3 = '0;
        Zero = 1'b0; ALUR31 = 1'b0; lt = 1'b0;
        adv(); adv();
        reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] seq_ops[6];
        int exp_ret[6];
        int exp_rw[6];
        int cyc, rw, pcw, mw, idx, rwc;
        logic done;
        logic [4:0] pat_pcw, pat_rw;

        itab[0] = '{OP_LOAD,   3'b010, 1'b0, 3'b000, 5, 1, 1, 0};
        itab[1] = '{OP_STORE,  3'b010, 1'b0, 3'b001, 4, 0, 1, 1};
        itab[2] = '{OP_REG,    3'b000, 1'b0, 3'b000, 4, 1, 1, 0};
        itab[3] = '{OP_IMM,    3'b000, 1'b0, 3'b000, 4, 1, 1, 0};
        itab[4] = '{OP_JAL,    3'b000, 1'b0, 3'b011, 4, 1, 2, 0};
        itab[5] = '{OP_JALR,   3'b000, 1'b0, 3'b000, 5, 1, 2, 0};
        itab[6] = '{OP_LUI,    3'b000, 1'b0, 3'b100, 3, 1, 1, 0};
        itab[7] = '{OP_AUIPC,  3'b000, 1'b0, 3'b100, 4, 1, 1, 0};
        itab[8] = '{OP_BRANCH, 3'b000, 1'b1, 3'b010, 3, 0, 2, 0};

        btab[0]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
        btab[1]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        btab[2]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
        btab[3]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
        btab[4]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
        btab[5]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
        btab[6]  = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0};
        btab[7]  = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1};
        btab[8]  = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
        btab[9]  = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
        btab[10] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
        btab[11] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1};
        btab[12] = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b0};
        btab[13] = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0};

        seq_ops = '{OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC};
        exp_ret = '{4, 8, 13, 17, 20, 24};
        exp_rw  = '{1, 1, 1, 0, 1, 1};

        // Reset state: strobes held low even with mem_ready high in FETCH.
        reset = 1'b1; mem_ready = 1'b1; op = OP_IMM;
        adv();
        settle();
        check("reset_strobes", strobes(), 0);
        check("reset_fault", fault, 0);
        adv();
        reset = 1'b0;
        settle();
        check("fetch_irwrite", IRWrite, 1);
        check("fetch_pcwrite", PCWrite, 1);
        check("fetch_alusrcb", ALUSrcB, 2);
        check("fetch_resultsrc", ResultSrc, 2);

        // Back-to-back sequence: retire cycles counted from reset release.
        do_reset();
        idx = 0; rwc = 0; op = seq_ops[0];
        for (int c = 1; c <= 40 && idx < 6; c++) begin
            settle();
            rwc += int'(RegWrite);
            if (instr_retired) begin
                check($sformatf("seq_retire_cycle_%0d", idx), c, exp_ret[idx]);
                check($sformatf("seq_regwrite_%0d", idx), rwc, exp_rw[idx]);
                rwc = 0;
                idx++;
            end
            adv();
            if (idx < 6) op = seq_ops[idx];
        end
        check("seq_all_retired", idx, 6);

        // Per-opcode table: latency, ImmSrc and strobe counts.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            op = itab[i].op; funct3 = itab[i].f3; Zero = itab[i].zero; mem_ready = 1'b1;
            cyc = 0; rw = 0; pcw = 0; mw = 0; done = 1'b0;
            while (!done && cyc < 12) begin
                settle();
                cyc++;
                if (cyc == 2) check($sformatf("tab%0d_immsrc", i), ImmSrc, itab[i].imm);
                rw  += int'(RegWrite);
                pcw += int'(PCWrite);
                mw  += int'(MemWrite);
                if (instr_retired) done = 1'b1;
                adv();
            end
            check($sformatf("tab%0d_cycles", i), cyc, itab[i].cycles);
            check($sformatf("tab%0d_regwrite", i), rw, itab[i].rw);
            check($sformatf("tab%0d_pcwrite", i), pcw, itab[i].pcw);
            check($sformatf("tab%0d_memwrite", i), mw, itab[i].mw);
        end

        // Branch resolution table.
        do_reset();
        op = OP_BRANCH;
        for (int i = 0; i < 14; i++) begin
            funct3 = btab[i].f3; Zero = btab[i].zero; ALUR31 = btab[i].r31; lt = btab[i].ltv;
            settle(); adv();
            settle();
            check($sformatf("br%0d_decode_pcw", i), PCWrite, 0);
            adv();
            settle();
            check($sformatf("br%0d_take_f3_%0d", i, btab[i].f3), PCWrite, btab[i].take);
            check($sformatf("br%0d_retire", i), instr_retired, 1);
            check($sformatf("br%0d_aluop", i), ALUOp, 1);
            check($sformatf("br%0d_fault", i), fault, 0);
            adv();
        end

        // lw with three wait cycles in MEMREAD.
        do_reset();
        op = OP_LOAD;
        ticks(3);
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("lw_wait%0d_adrsrc", c), AdrSrc, 1);
            check($sformatf("lw_wait%0d_regwrite", c), RegWrite, 0);
            check($sformatf("lw_wait%0d_retire", c), instr_retired, 0);
            adv();
        end
        mem_ready = 1'b1;
        settle();
        check("lw_ready_regwrite", RegWrite, 0);
        check("lw_ready_adrsrc", AdrSrc, 1);
        adv();
        settle();
        check("lw_memwb_regwrite", RegWrite, 1);
        check("lw_memwb_resultsrc", ResultSrc, 1);
        check("lw_memwb_retire", instr_retired, 1);
        adv();

        // sw with three wait cycles: MemWrite must span exactly four cycles.
        do_reset();
        op = OP_STORE; mw = 0; rwc = 0;
        ticks(2);
        settle();
        check("sw_memadr_srca", ALUSrcA, 2);
        check("sw_memadr_srcb", ALUSrcB, 1);
        adv();
        mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) mem_ready = 1'b1;
            settle();
            mw  += int'(MemWrite);
            rwc += int'(instr_retired);
            if (c == 3) check("sw_retire_on_ready", instr_retired, 1);
            adv();
        end
        check("sw_memwrite_cycles", mw, 4);
        check("sw_retire_count", rwc, 1);

        // mem_ready arriving on the last allowed wait cycle beats the timeout.
        do_reset();
        op = OP_IMM; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("edge_wait%0d_irwrite", c), IRWrite, 0);
            adv();
        end
        mem_ready = 1'b1;
        settle();
        check("edge_ready_irwrite", IRWrite, 1);
        adv();
        settle();
        check("edge_decode_fault", fault, 0);
        check("edge_decode_srca", ALUSrcA, 1);

        // Timeout in FETCH: four waiting cycles, then FAULT until reset.
        do_reset();
        op = OP_IMM; mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("to_wait%0d_irwrite", c), IRWrite, 0);
            check($sformatf("to_wait%0d_fault", c), fault, 0);
            adv();
        end
        settle();
        check("to_fault_set", fault, 1);
        check("to_fault_strobes", strobes(), 0);
        mem_ready = 1'b1;
        adv();
        settle();
        check("to_fault_sticky", fault, 1);
        check("to_fault_no_irwrite", IRWrite, 0);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        settle();
        check("to_reset_fault_clear", fault, 0);
        check("to_reset_fetch", IRWrite, 1);

        // Illegal opcode: DECODE then FAULT with no strobes.
        do_reset();
        op = 7'b0000000;
        adv();
        settle();
        check("ill_decode_strobes", strobes(), 0);
        check("ill_decode_fault", fault, 0);
        adv();
        settle();
        check("ill_fault_set", fault, 1);
        check("ill_fault_strobes", strobes(), 0);
        adv();
        settle();
        check("ill_fault_stays", fault, 1);

        // jal then jalr: cycle-by-cycle PCWrite/RegWrite pattern.
        do_reset();
        op = OP_JAL; pat_pcw = 5'b00101; pat_rw = 5'b01000;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("jal_c%0d_pcw", c), PCWrite, pat_pcw[c]);
            check($sformatf("jal_c%0d_rw", c), RegWrite, pat_rw[c]);
            adv();
        end
        op = OP_JALR; pat_pcw = 5'b01001; pat_rw = 5'b10000;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("jalr_c%0d_pcw", c), PCWrite, pat_pcw[c]);
            check($sformatf("jalr_c%0d_rw", c), RegWrite, pat_rw[c]);
            if (c == 3) check("jalrpc_srca", ALUSrcA, 1);
            if (c == 4) check("jalr_retire", instr_retired, 1);
            adv();
        end

        // Reset while a store is waiting in MEMWRITE.
        do_reset();
        op = OP_STORE;
        ticks(3);
        mem_ready = 1'b0;
        settle();
        check("rst_mw_before", MemWrite, 1);
        adv();
        reset = 1'b1;
        settle();
        check("rst_mw_memwrite", MemWrite, 0);
        check("rst_mw_retire", instr_retired, 0);
        adv();
        reset = 1'b0; mem_ready = 1'b1;
        settle();
        check("rst_mw_fetch_irwrite", IRWrite, 1);
        check("rst_mw_fetch_adrsrc", AdrSrc, 0);
        check("rst_mw_fetch_retire", instr_retired, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
